// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold / shift right / shift left / parallel load,
// with a saturating shift counter and Done flag. Define USR_ROTATE_EN to add the Rot input.
module univ_shift_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           CNTW      = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             DSR,
    input  logic             DSL,
`ifdef USR_ROTATE_EN
    input  logic             Rot,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SOR,
    output logic             SOL,
    output logic [CNTW-1:0]  Cnt,
    output logic             Done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CNTW-1:0]  cnt_nxt;
    logic             done_nxt;
    logic             fill_r;
    logic             fill_l;
    logic             shifting;

    // Serial fill bits; rotation recirculates the bit leaving the opposite end.
    always_comb begin
        fill_r = DSR;
        fill_l = DSL;
`ifdef USR_ROTATE_EN
        if (Rot) begin
            fill_r = Q[0];
            fill_l = Q[WIDTH-1];
        end
`endif
    end

    // Next-state logic for data, counter and Done.
    always_comb begin
        q_nxt    = Q;
        cnt_nxt  = Cnt;
        done_nxt = Done;
        shifting = 1'b0;
        if (En) begin
            case (Mode)
                MODE_SHR: begin
                    q_nxt    = {fill_r, Q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    q_nxt    = {Q[WIDTH-2:0], fill_l};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt    = D;
                    cnt_nxt  = '0;
                    done_nxt = 1'b0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
        // Counter saturates at WIDTH; Done rises on the same edge it gets there.
        if (shifting) begin
            if (Cnt < CNT_FULL) begin
                cnt_nxt = Cnt + CNTW'(1);
            end
            done_nxt = (cnt_nxt == CNT_FULL);
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            Q    <= RESET_VAL;
            Qn   <= ~RESET_VAL;
            Cnt  <= '0;
            Done <= 1'b0;
        end else begin
            Q    <= q_nxt;
            Qn   <= ~q_nxt;
            Cnt  <= cnt_nxt;
            Done <= done_nxt;
        end
    end

    assign SOR = Q[0];
    assign SOL = Q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: driver pushes model predictions, monitor checks after each edge.
module tb_univ_shift_reg;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'hA5;
    localparam int unsigned CW = $clog2(W + 1);

    logic          Clk = 1'b0;
    logic          R   = 1'b1;
    logic          En  = 1'b0;
    logic [1:0]    Mode = 2'b00;
    logic [W-1:0]  D   = '0;
    logic          DSR = 1'b0;
    logic          DSL = 1'b0;
    logic          Rot = 1'b0;
    logic [W-1:0]  Q, Qn;
    logic          SOR, SOL, Done;
    logic [CW-1:0] Cnt;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .Clk(Clk), .R(R), .En(En), .Mode(Mode), .D(D), .DSR(DSR), .DSL(DSL),
`ifdef USR_ROTATE_EN
        .Rot(Rot),
`endif
        .Q(Q), .Qn(Qn), .SOR(SOR), .SOL(SOL), .Cnt(Cnt), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] q;
        int         cnt;
        logic       done;
    } exp_t;

    exp_t sb[$];
    logic [7:0] m_q = RV;
    int         m_cnt = 0;
    logic       m_done = 1'b0;
    int errors = 0;
    int checks = 0;

    task automatic push_exp();
        exp_t e;
        e.q = m_q; e.cnt = m_cnt; e.done = m_done;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_q = RV; m_cnt = 0; m_done = 1'b0;
    endtask

    // Direct comparison of current DUT state against bench-supplied values.
    task automatic check_now(input string name, input logic [7:0] q, input int cnt, input logic done);
        checks++;
        if (Q !== q || Qn !== ~q || Cnt !== CW'(cnt) || Done !== done || SOR !== q[0] || SOL !== q[7]) begin
            errors++;
            $display("FAIL %s: got Q=%h Qn=%h Cnt=%0d Done=%b SOR=%b SOL=%b, want Q=%h Qn=%h Cnt=%0d Done=%b",
                     name, Q, Qn, Cnt, Done, SOR, SOL, q, ~q, cnt, done);
        end
    endtask

    // Drive one cycle at a negedge, predict the post-edge state, wait for the next negedge.
    task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] d,
                        input logic dsr, input logic dsl, input logic rot);
        int fr, fl;
        En = en; Mode = mode; D = d; DSR = dsr; DSL = dsl; Rot = rot;
        fr = int'(dsr);
        fl = int'(dsl);
`ifdef USR_ROTATE_EN
        if (rot) begin
            fr = int'(m_q) % 2;
            fl = int'(m_q) / 128;
        end
`endif
        if (en && mode != 2'b00) begin
            if (mode == 2'b11) begin
                m_q = d; m_cnt = 0; m_done = 1'b0;
            end else begin
                if (mode == 2'b01) m_q = 8'((int'(m_q) / 2) + fr * 128);
                else               m_q = 8'((int'(m_q) * 2 + fl) % 256);
                if (m_cnt < W) m_cnt++;
                if (m_cnt == W) m_done = 1'b1;
            end
        end
        push_exp();
        @(negedge Clk);
    endtask

    // Asynchronous clear between edges, checked before any clock edge, held across one edge.
    task automatic pulse_reset(input string name);
        #2 R = 1'b0;
        #1 model_reset();
        check_now(name, RV, 0, 1'b0);
        push_exp();
        @(negedge Clk);
        R = 1'b1;
    endtask

    // Monitor: after every rising edge, pop and compare any pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (Q !== e.q || Qn !== ~e.q || Cnt !== CW'(e.cnt) || Done !== e.done ||
                    SOR !== e.q[0] || SOL !== e.q[7]) begin
                    errors++;
                    $display("FAIL sb @%0t: got Q=%h Qn=%h Cnt=%0d Done=%b SOR=%b SOL=%b, want Q=%h Cnt=%0d Done=%b",
                             $time, Q, Qn, Cnt, Done, SOR, SOL, e.q, e.cnt, e.done);
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int guard;
        pat = 8'b1011_0010;
        #3 R = 1'b0;
        #1 check_now("init_reset", RV, 0, 1'b0);
        @(negedge Clk);
        R = 1'b1;

        // Parallel-to-serial: load B4 then shift right, saturating past WIDTH.
        step(1, 2'b11, 8'hB4, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 2'b01, 8'h00, 0, 0, 0);
        check_now("shr8", 8'h00, 8, 1'b1);
        step(1, 2'b01, 8'h00, 0, 0, 0);
        check_now("shr9_sat", 8'h00, 8, 1'b1);

        // Serial-to-parallel from a cleared register, MSB of pattern first.
        pulse_reset("rst_before_shl");
        for (int i = 7; i >= 0; i--) step(1, 2'b10, 8'h00, 0, pat[i], 0);
        check_now("shl8", 8'hB2, 8, 1'b1);
        step(1, 2'b11, 8'h3C, 0, 0, 0);
        check_now("load_clears", 8'h3C, 0, 1'b0);

        for (int i = 0; i < 3; i++) step(0, 2'b01, 8'hFF, 1, 1, 0);
        check_now("en_low", 8'h3C, 0, 1'b0);
        step(1, 2'b00, 8'hFF, 1, 1, 0);
        check_now("hold", 8'h3C, 0, 1'b0);

        for (int i = 0; i < 4; i++) step(1, 2'b01, 8'h00, 1, 0, 0);
        check_now("mid_shift", 8'hF3, 4, 1'b0);
        pulse_reset("rst_mid_shift");
        step(1, 2'b01, 8'h00, 1, 0, 0);
        check_now("shift_after_rst", 8'hD2, 1, 1'b0);

`ifdef USR_ROTATE_EN
        step(1, 2'b11, 8'h81, 0, 0, 0);
        step(1, 2'b01, 8'h00, 0, 0, 1);
        check_now("rotr", 8'hC0, 1, 1'b0);
        step(1, 2'b11, 8'h81, 0, 0, 0);
        step(1, 2'b10, 8'h00, 0, 0, 1);
        check_now("rotl", 8'h03, 1, 1'b0);
`endif

        // Randomised traffic, loads rare enough that the counter saturates often.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            if (md == 2'b11 && $urandom_range(0, 3) != 0) md = 2'b01;
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
            else step(1'($urandom_range(0, 5) != 0), md, 8'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
